score_ctrl: RTL and testbench

SCORE_CTRL -- requirements
Module: score_ctrl

---
 rtl/pong_pkg.sv | 22 ++
 rtl/pause_timer.sv | 31 +++
 rtl/score_ctrl.sv | 162 ++++++++++++++++
 tb/tb_score_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared game constants and state encodings for the pong score/display logic.
package pong_pkg;

  localparam int WIN_SCORE_DEF   = 9;
  localparam int PAUSE_TICKS_DEF = 60;
  localparam int SCORE_W         = 4;
  localparam int CNT_W           = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PAUSE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  // Identifies a player; also used as the round-robin tie-break priority.
  typedef enum logic {
    PLR_1 = 1'b0,
    PLR_2 = 1'b1
  } player_t;

endpackage

// File: rtl/pause_timer.sv
// Frame-tick countdown between a point (or start) and the next serve.
// done fires combinationally on the tick that moves the count from 1 to 0.
module pause_timer
  import pong_pkg::*;
#(
  parameter int LOAD_VAL = PAUSE_TICKS_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic tick,
  output logic done
);

  logic [CNT_W-1:0] r_count;

  // Countdown register: load wins over tick, stops at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (load) begin
      // NOTE: non-blocking assignment so every register samples pre-edge values.
      r_count <= CNT_W'(LOAD_VAL);
    end else if (tick && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign done = tick && !load && (r_count == CNT_W'(1));

endmodule

// File: rtl/score_ctrl.sv
// Pong score controller: game FSM, score registers and tie arbiter.
// All outputs are registered; next values come from one combinational block.
module score_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = WIN_SCORE_DEF,
  parameter int PAUSE_TICKS = PAUSE_TICKS_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       point_p1,
  input  logic       point_p2,
  input  logic       tick,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic       serve,
  output logic       serve_dir,
  output logic       playing,
  output logic       game_over
);

  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

  state_t               r_state;
  logic [SCORE_W-1:0]   r_score_p1;
  logic [SCORE_W-1:0]   r_score_p2;
  logic                 r_serve;
  logic                 r_serve_dir;
  logic                 r_playing;
  logic                 r_game_over;
  player_t              r_prio;

  state_t               w_state_nxt;
  logic [SCORE_W-1:0]   w_score_p1_nxt;
  logic [SCORE_W-1:0]   w_score_p2_nxt;
  logic [SCORE_W-1:0]   w_inc_p1;
  logic [SCORE_W-1:0]   w_inc_p2;
  logic                 w_serve_nxt;
  logic                 w_dir_nxt;
  player_t              w_prio_nxt;
  logic                 w_load;
  logic                 w_award_p1;
  logic                 w_award_p2;
  logic                 w_tick_pause;
  logic                 w_done;

  // Ticks only count down while the FSM is waiting to serve.
  assign w_tick_pause = tick && (r_state == ST_PAUSE);

  // Saturating increments: a score never passes WIN_SCORE and never wraps.
  assign w_inc_p1 = (r_score_p1 < WIN) ? r_score_p1 + 1'b1 : r_score_p1;
  assign w_inc_p2 = (r_score_p2 < WIN) ? r_score_p2 + 1'b1 : r_score_p2;

  pause_timer #(
    .LOAD_VAL (PAUSE_TICKS)
  ) u_pause_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (w_load),
    .tick    (w_tick_pause),
    .done    (w_done)
  );

  // Next-state, next-score, arbitration and serve decisions.
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latch).
    w_state_nxt    = r_state;
    w_score_p1_nxt = r_score_p1;
    w_score_p2_nxt = r_score_p2;
    w_serve_nxt    = 1'b0;
    w_dir_nxt      = r_serve_dir;
    w_prio_nxt     = r_prio;
    w_load         = 1'b0;
    w_award_p1     = 1'b0;
    w_award_p2     = 1'b0;

    case (r_state)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          w_score_p1_nxt = '0;
          w_score_p2_nxt = '0;
          w_load         = 1'b1;
          w_state_nxt    = ST_PAUSE;
        end
      end

      ST_PAUSE: begin
        if (w_done) begin
          w_serve_nxt = 1'b1;
          w_state_nxt = ST_PLAY;
        end
      end

      ST_PLAY: begin
        // A tie goes to whoever was not awarded last; the other pulse is lost.
        if (point_p1 && point_p2) begin
          w_award_p1 = (r_prio == PLR_1);
          w_award_p2 = (r_prio == PLR_2);
        end else begin
          w_award_p1 = point_p1;
          w_award_p2 = point_p2;
        end

        if (w_award_p1) begin
          w_score_p1_nxt = w_inc_p1;
          w_dir_nxt      = 1'b1;
          w_prio_nxt     = PLR_2;
          if (w_inc_p1 == WIN) begin
            w_state_nxt = ST_OVER;
          end else begin
            w_state_nxt = ST_PAUSE;
            w_load      = 1'b1;
          end
        end else if (w_award_p2) begin
          w_score_p2_nxt = w_inc_p2;
          w_dir_nxt      = 1'b0;
          w_prio_nxt     = PLR_1;
          if (w_inc_p2 == WIN) begin
            w_state_nxt = ST_OVER;
          end else begin
            w_state_nxt = ST_PAUSE;
            w_load      = 1'b1;
          end
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and output registers; status flags track the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_score_p1  <= '0;
      r_score_p2  <= '0;
      r_serve     <= 1'b0;
      r_serve_dir <= 1'b0;
      r_playing   <= 1'b0;
      r_game_over <= 1'b0;
      r_prio      <= PLR_1;
    end else begin
      r_state     <= w_state_nxt;
      r_score_p1  <= w_score_p1_nxt;
      r_score_p2  <= w_score_p2_nxt;
      r_serve     <= w_serve_nxt;
      r_serve_dir <= w_dir_nxt;
      r_playing   <= (w_state_nxt == ST_PLAY);
      r_game_over <= (w_state_nxt == ST_OVER);
      r_prio      <= w_prio_nxt;
    end
  end

  assign score_p1  = r_score_p1;
  assign score_p2  = r_score_p2;
  assign serve     = r_serve;
  assign serve_dir = r_serve_dir;
  assign playing   = r_playing;
  assign game_over = r_game_over;

endmodule

// File: tb/tb_score_ctrl.sv
// Scoreboard bench for score_ctrl: stimulus queues every expected output
// change; the monitor pops one entry each time the output vector changes.
module tb_score_ctrl;
  import pong_pkg::*;

  localparam int PT = 60;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0, point_p1 = 1'b0, point_p2 = 1'b0, tick = 1'b0;
  logic [3:0] score_p1, score_p2;
  logic       serve, serve_dir, playing, game_over;

  logic       start_w3 = 1'b0, point_p1_w3 = 1'b0, point_p2_w3 = 1'b0, tick_w3 = 1'b0;
  logic [3:0] score_p1_w3, score_p2_w3;
  logic       serve_w3, serve_dir_w3, playing_w3, game_over_w3;

  typedef struct {
    logic [11:0] vec;
    int          ticks;   // -1: tick count not checked for this event
  } exp_t;

  exp_t sb[$];
  int   tick_cnt = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  score_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start(start), .point_p1(point_p1),
    .point_p2(point_p2), .tick(tick), .score_p1(score_p1), .score_p2(score_p2),
    .serve(serve), .serve_dir(serve_dir), .playing(playing), .game_over(game_over)
  );

  score_ctrl #(.WIN_SCORE(3), .PAUSE_TICKS(2)) dut_w3 (
    .clk(clk), .reset_n(reset_n), .start(start_w3), .point_p1(point_p1_w3),
    .point_p2(point_p2_w3), .tick(tick_w3), .score_p1(score_p1_w3),
    .score_p2(score_p2_w3), .serve(serve_w3), .serve_dir(serve_dir_w3),
    .playing(playing_w3), .game_over(game_over_w3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_ev(input logic [3:0] p1, input logic [3:0] p2, input logic sv,
                           input logic dir, input logic pl, input logic ov, input int tk);
    exp_t e;
    e.vec   = {p1, p2, sv, dir, pl, ov};
    e.ticks = tk;
    sb.push_back(e);
  endtask

  // One-cycle input pulse, applied 1 time unit after a rising edge.
  task automatic pulse(input logic st, input logic a, input logic b, input logic tk);
    @(posedge clk); #1;
    start = st; point_p1 = a; point_p2 = b; tick = tk;
    @(posedge clk); #1;
    start = 1'b0; point_p1 = 1'b0; point_p2 = 1'b0; tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      pulse(1'b0, 1'b0, 1'b0, 1'b1);
      tick_cnt++;
    end
  endtask

  // Full pause: serve must rise exactly on the PT-th tick, then fall.
  task automatic serve_ev(input logic [3:0] p1, input logic [3:0] p2, input logic dir);
    expect_ev(p1, p2, 1'b1, dir, 1'b1, 1'b0, PT);
    expect_ev(p1, p2, 1'b0, dir, 1'b1, 1'b0, -1);
    tick_cnt = 0;
    ticks(PT);
  endtask

  task automatic pulse_w3(input logic st, input logic a, input logic tk);
    @(posedge clk); #1;
    start_w3 = st; point_p1_w3 = a; tick_w3 = tk;
    @(posedge clk); #1;
    start_w3 = 1'b0; point_p1_w3 = 1'b0; tick_w3 = 1'b0;
  endtask

  // Monitor: every change of the output vector must match the next expectation.
  initial begin
    logic [11:0] prev, cur;
    exp_t        e;
    prev = '1;
    forever begin
      @(negedge clk);
      cur = {score_p1, score_p2, serve, serve_dir, playing, game_over};
      if (cur !== prev) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_change: got %03h, previous %03h (t=%0t)", cur, prev, $time);
        end else begin
          e = sb.pop_front();
          check("outputs", 32'(cur), 32'(e.vec));
          if (e.ticks >= 0) check("serve_tick_count", tick_cnt, e.ticks);
        end
        prev = cur;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state.
    expect_ev(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // IDLE ignores points and ticks.
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(3);

    // Start, ignored point in PAUSE, serve on the 60th tick toward player 1.
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    serve_ev(4'd0, 4'd0, 1'b0);

    // Ticks in PLAY do nothing; first tie after reset goes to player 1.
    ticks(5);
    expect_ev(4'd1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    pulse(1'b0, 1'b1, 1'b1, 1'b0);
    serve_ev(4'd1, 4'd0, 1'b1);

    // Second tie goes to player 2.
    expect_ev(4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    pulse(1'b0, 1'b1, 1'b1, 1'b0);
    serve_ev(4'd1, 4'd1, 1'b0);

    // Player 2 point with a tick in the same cycle; point in PAUSE ignored.
    expect_ev(4'd1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    pulse(1'b0, 1'b0, 1'b1, 1'b1);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    serve_ev(4'd1, 4'd2, 1'b0);

    // Reset with 5 ticks left in PAUSE: immediate clear, no later serve.
    expect_ev(4'd2, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    tick_cnt = 0;
    ticks(PT - 5);
    expect_ev(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    @(posedge clk); #1 reset_n = 1'b0;
    #1 check("reset_immediate", 32'({score_p1, score_p2, serve, serve_dir, playing, game_over}), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    ticks(100);

    // New game: tie priority is back at player 1.
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    serve_ev(4'd0, 4'd0, 1'b0);
    expect_ev(4'd1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    pulse(1'b0, 1'b1, 1'b1, 1'b0);

    // Drive player 1 up to 8, then the winning point.
    for (int s = 1; s < 8; s++) begin
      logic [3:0] sc;
      sc = 4'(s);
      serve_ev(sc, 4'd0, 1'b1);
      expect_ev(sc + 4'd1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, -1);
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
    end
    serve_ev(4'd8, 4'd0, 1'b1);
    expect_ev(4'd9, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);

    // OVER holds everything against points and ticks.
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b1, 1'b0);
    ticks(PT);

    // Start from OVER clears scores and pauses as from IDLE.
    expect_ev(4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    serve_ev(4'd0, 4'd0, 1'b1);

    repeat (5) @(posedge clk);
    check("scoreboard_drained", sb.size(), 0);

    // Short build: WIN_SCORE=3, PAUSE_TICKS=2.
    pulse_w3(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      pulse_w3(1'b0, 1'b0, 1'b1);
      pulse_w3(1'b0, 1'b0, 1'b1);
      pulse_w3(1'b0, 1'b1, 1'b0);
      check("w3_score_p1", 32'(score_p1_w3), k);
      check("w3_game_over", 32'(game_over_w3), (k == 3) ? 1 : 0);
    end
    pulse_w3(1'b0, 1'b0, 1'b1);
    pulse_w3(1'b0, 1'b0, 1'b1);
    pulse_w3(1'b0, 1'b1, 1'b0);
    check("w3_score_saturated", 32'(score_p1_w3), 3);
    check("w3_still_over", 32'({game_over_w3, playing_w3, serve_w3}), 32'b100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
